// File: rtl/alu_interface_if.sv
// alu_interface_if: receiver/ALU/transmitter signals of the ALU front end.
interface alu_interface_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic i_rx_valid;
  logic [NB_DATA-1:0] i_alu_result;
  logic i_tx_done;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0] o_alu_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic o_tx_start;
  logic o_busy;
  logic o_err;
  modport slave (
    input i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err
  );
  modport master (
    output i_rx_data, i_rx_valid, i_alu_result, i_tx_done,
    input o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err
  );
endinterface

// File: rtl/alu_interface.sv
// alu_interface: collects A, B and opcode bytes, runs the ALU, hands the result to the transmitter.
module alu_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP = 6
) (
  input logic i_clk,
  input logic i_rst_n,
  alu_interface_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX} state_t;
  state_t state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [NB_OP-1:0] op_q, op_d, op_lo;
  logic start_q, start_d, busy_q, busy_d, err_q, err_d, op_ok;
  assign op_lo = bus.i_rx_data[NB_OP-1:0];
  // Opcode bits above NB_OP must be clear, otherwise the byte is rejected.
  assign op_ok = ((bus.i_rx_data >> NB_OP) == '0) &&
                 (op_lo inside {NB_OP'(6'h20), NB_OP'(6'h22), NB_OP'(6'h24), NB_OP'(6'h25),
                                NB_OP'(6'h26), NB_OP'(6'h27), NB_OP'(6'h03), NB_OP'(6'h02)});
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    tx_d = tx_q;
    start_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.i_rx_valid) begin
        a_d = bus.i_rx_data;
        state_d = WAIT_B;
      end
      WAIT_B: if (bus.i_rx_valid) begin
        b_d = bus.i_rx_data;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (bus.i_rx_valid) begin
        op_d = op_ok ? op_lo : op_q;
        err_d = !op_ok;
        state_d = op_ok ? EXEC : IDLE;
      end
      EXEC: begin
        tx_d = bus.i_alu_result;
        start_d = 1'b1;
        state_d = SEND;
      end
      SEND: state_d = WAIT_TX;
      WAIT_TX: state_d = bus.i_tx_done ? IDLE : WAIT_TX;
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {EXEC, SEND, WAIT_TX};
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      tx_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      tx_q <= tx_d;
      start_q <= start_d;
      busy_q <= busy_d;
      err_q <= err_d;
    end
  end
  assign bus.o_alu_a = a_q;
  assign bus.o_alu_b = b_q;
  assign bus.o_alu_op = op_q;
  assign bus.o_tx_data = tx_q;
  assign bus.o_tx_start = start_q;
  assign bus.o_busy = busy_q;
  assign bus.o_err = err_q;
endmodule

// File: tb/tb_alu_interface.sv
// tb_alu_interface: directed and random byte streams checked against a transaction-level model.
module tb_alu_interface;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  alu_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();
  alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20: return a + b;
      6'h22: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h03: return $signed(a) >>> b;
      6'h02: return a >> b;
      default: return 8'h00;
    endcase
  endfunction
  assign bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, got, exp, $time);
    end
  endtask
  // Model: bytes collected so far (0..2) and cycles elapsed since an opcode was accepted (0 = idle).
  logic [7:0] m_a = 0, m_b = 0, m_tx = 0;
  logic [5:0] m_op = 0;
  logic m_start = 0, m_err = 0;
  int m_bytes = 0, m_age = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_a <= 0; m_b <= 0; m_op <= 0; m_tx <= 0; m_start <= 0; m_err <= 0;
      m_bytes <= 0; m_age <= 0;
    end else begin
      m_start <= 0;
      m_err <= 0;
      if (m_age == 0) begin
        if (bus.i_rx_valid) begin
          if (m_bytes == 0) m_a <= bus.i_rx_data;
          if (m_bytes == 1) m_b <= bus.i_rx_data;
          m_bytes <= (m_bytes + 1) % 3;
          if (m_bytes == 2) begin
            if (bus.i_rx_data inside {8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02}) begin
              m_op <= bus.i_rx_data[5:0];
              m_age <= 1;
            end else m_err <= 1;
          end
        end
      end else begin
        if (m_age == 1) begin
          m_tx <= alu_f(m_a, m_b, m_op);
          m_start <= 1;
        end
        m_age <= (m_age >= 3) ? (bus.i_tx_done ? 0 : 3) : m_age + 1;
      end
    end
  end
  always @(negedge clk) begin
    chk("alu_a", bus.o_alu_a, m_a);
    chk("alu_b", bus.o_alu_b, m_b);
    chk("alu_op", bus.o_alu_op, m_op);
    chk("tx_data", bus.o_tx_data, m_tx);
    chk("tx_start", bus.o_tx_start, m_start);
    chk("busy", bus.o_busy, m_age != 0);
    chk("err", bus.o_err, m_err);
  end
  task automatic send(input logic [7:0] d);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data = d;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask
  task automatic tx_done_pulse();
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask
  logic [7:0] pool [12] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02,
                             8'h60, 8'hA2, 8'h21, 8'h00};
  initial begin
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_tx_done = 1'b0;
    @(negedge clk);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data = 8'h55;
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {bus.o_alu_a, bus.o_alu_b, bus.o_tx_data, 2'b0, bus.o_alu_op}, 32'h0);
    chk("rst_flags", {bus.o_tx_start, bus.o_busy, bus.o_err}, 3'b000);
    rst_n = 1'b1;
    send(8'h05);
    chk("add_a", bus.o_alu_a, 8'h05);
    send(8'h03);
    chk("add_b", bus.o_alu_b, 8'h03);
    send(8'h20);
    chk("add_op", bus.o_alu_op, 6'h20);
    chk("add_nostart_exec", bus.o_tx_start, 1'b0);
    @(negedge clk);
    chk("add_start", bus.o_tx_start, 1'b1);
    chk("add_result", bus.o_tx_data, 8'h08);
    @(negedge clk);
    chk("add_start_once", bus.o_tx_start, 1'b0);
    chk("add_busy_wait", bus.o_busy, 1'b1);
    tx_done_pulse();
    chk("add_busy_drop", bus.o_busy, 1'b0);
    send(8'h03);
    send(8'h05);
    send(8'h22);
    @(negedge clk);
    chk("sub_result", bus.o_tx_data, 8'hFE);
    @(negedge clk);
    tx_done_pulse();
    send(8'h10);
    send(8'h20);
    send(8'h21);
    chk("inv_err", bus.o_err, 1'b1);
    chk("inv_op_kept", bus.o_alu_op, 6'h22);
    @(negedge clk);
    chk("inv_err_once", bus.o_err, 1'b0);
    chk("inv_nostart", bus.o_tx_start, 1'b0);
    send(8'h07);
    chk("inv_next_a", bus.o_alu_a, 8'h07);
    send(8'h01);
    send(8'h20);
    @(negedge clk);
    chk("drop_start", bus.o_tx_start, 1'b1);
    tx_done_pulse();
    send(8'h11);
    chk("drop_a_kept", bus.o_alu_a, 8'h07);
    repeat (3) @(negedge clk);
    chk("drop_still_busy", bus.o_busy, 1'b1);
    tx_done_pulse();
    chk("drop_idle", bus.o_busy, 1'b0);
    send(8'h09);
    send(8'h04);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_a", bus.o_alu_a, 8'h00);
    chk("midrst_nostart", bus.o_tx_start, 1'b0);
    send(8'h01);
    send(8'h01);
    send(8'h20);
    @(negedge clk);
    chk("midrst_result", bus.o_tx_data, 8'h02);
    chk("midrst_start", bus.o_tx_start, 1'b1);
    @(negedge clk);
    tx_done_pulse();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      bus.i_rx_valid = ($urandom_range(0, 2) == 0);
      bus.i_rx_data = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 11)] : 8'($urandom);
      bus.i_tx_done = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_done = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_interface.md
ALU_INTERFACE -- requirements
Module: alu_interface

Interface
REQ-001 Parameter NB_DATA, default 8, operand/result width in bits; it SHALL equal the receiver/transmitter byte width.
REQ-002 Parameter NB_OP, default 6, ALU opcode width; it SHALL be at most NB_DATA.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_rx_data  input  NB_DATA  byte from the serial receiver.
REQ-006 i_rx_valid  input  1  one-cycle pulse; i_rx_data is valid in that cycle.
REQ-007 i_alu_result  input  NB_DATA  combinational result from the ALU.
REQ-008 i_tx_done  input  1  one-cycle pulse; the transmitter has finished the current byte.
REQ-009 o_alu_a  output  NB_DATA  operand A to the ALU.
REQ-010 o_alu_b  output  NB_DATA  operand B to the ALU.
REQ-011 o_alu_op  output  NB_OP  opcode to the ALU.
REQ-012 o_tx_data  output  NB_DATA  result byte to the transmitter.
REQ-013 o_tx_start  output  1  one-cycle pulse; the transmitter latches o_tx_data.
REQ-014 o_busy  output  1  high while a result is being produced or sent.
REQ-015 o_err  output  1  one-cycle pulse when an opcode is rejected.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT_B, WAIT_OP, EXEC, SEND and WAIT_TX, all registered.
REQ-017 IDLE + i_rx_valid: o_alu_a <= i_rx_data and state -> WAIT_B.
REQ-018 WAIT_B + i_rx_valid: o_alu_b <= i_rx_data and state -> WAIT_OP.
REQ-019 The valid opcodes SHALL be 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x03 SRA and 0x02 SRL; the bits of i_rx_data above NB_OP-1 SHALL be zero.
REQ-020 WAIT_OP + i_rx_valid + valid opcode: o_alu_op <= i_rx_data[NB_OP-1:0] and state -> EXEC.
REQ-021 WAIT_OP + i_rx_valid + invalid opcode: o_alu_op is unchanged, o_err = 1 for the next cycle only, and state -> IDLE.
REQ-022 EXEC, one cycle so the ALU settles: o_tx_data <= i_alu_result, o_tx_start <= 1, and state -> SEND.
REQ-023 SEND, one cycle: o_tx_start <= 0 and state -> WAIT_TX; o_tx_start SHALL therefore be high for exactly one cycle.
REQ-024 Latency: o_tx_start SHALL be high in the second cycle after the edge that samples the opcode byte.
REQ-025 WAIT_TX + i_tx_done: state -> IDLE.
REQ-026 i_tx_done SHALL be ignored in every other state, including the SEND cycle.
REQ-027 i_rx_valid SHALL be ignored (byte dropped, no register change) in EXEC, SEND and WAIT_TX.
REQ-028 o_busy SHALL be registered and high exactly while the state is EXEC, SEND or WAIT_TX.
REQ-029 o_alu_a, o_alu_b, o_alu_op and o_tx_data SHALL hold their values until next written.
REQ-030 No operand or opcode register SHALL change in any cycle without i_rx_valid.
REQ-031 Operands SHALL be passed through without width change or sign manipulation.

Reset
REQ-032 While i_rst_n = 0 at a rising edge: state -> IDLE and every output -> 0 (o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_err).
REQ-033 Reset asserted in any state, including mid-sequence or during SEND/WAIT_TX, SHALL abort the operation, produce no o_tx_start, and discard any partially received operands.
REQ-034 Reset SHALL take priority over i_rx_valid and i_tx_done in the same cycle.

Verification
REQ-035 Reset: hold i_rst_n = 0 for 2 cycles with i_rx_valid pulsing -> all outputs are 0 and the state is IDLE after release.
REQ-036 ADD: bytes 0x05, 0x03, 0x20 with the real ALU attached -> o_alu_a = 0x05, o_alu_b = 0x03, o_alu_op = 0x20; o_tx_data = 0x08; o_tx_start pulses once, 2 cycles after the opcode edge; o_busy stays high until the cycle after i_tx_done.
REQ-037 SUB with a negative result: bytes 0x03, 0x05, 0x22 -> o_tx_data = 0xFE (-2).
REQ-038 Invalid opcode: bytes 0x10, 0x20, 0x21 -> o_err pulses for one cycle, o_tx_start stays 0, o_alu_op keeps its previous value, and the next byte 0x07 loads o_alu_a.
REQ-039 Busy drop: complete an ADD, then send byte 0x11 during WAIT_TX and pulse i_tx_done in the SEND cycle -> o_alu_a is unchanged and the FSM stays in WAIT_TX until a later i_tx_done.
REQ-040 Reset mid-op: bytes 0x09, 0x04, then i_rst_n = 0 for 1 cycle, then bytes 0x01, 0x01, 0x20 -> no o_tx_start before reset, and the post-reset result is 0x02.
